// File: rtl/sharp_out_formatter.sv
// Output stage of the sharpening core: clamps signed samples to 8 bits, tags SOF/EOL/EOF
// and buffers them in a small FIFO. Optional SHARP_SAT_COUNT_EN adds a per-frame clamp counter.
module sharp_out_formatter #(
    parameter int N     = 128,
    parameter int M     = 11,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M:0]   in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_pixel,
    output logic         out_sof,
    output logic         out_eol,
    output logic         out_eof,
    output logic         frame_done
`ifdef SHARP_SAT_COUNT_EN
    ,
    output logic [$clog2(N*N):0] sat_count
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
    } entry_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   row_q, row_d, col_q, col_d;
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     count_q, count_d;
    logic            rdy_en_q;
    entry_t          mem_q [DEPTH];
    entry_t          push_e, head;
    logic            push, pop, neg, big, sat;

    // Clamp: sign bit means negative; any set bit above bit 7 on a positive value means > 255.
    assign neg = in_data[M];
    assign big = !neg && (in_data > (M+1)'(255));
    assign sat = neg | big;

    always_comb begin
        push_e.pix = neg ? 8'd0 : (big ? 8'hFF : in_data[7:0]);
        push_e.sof = (row_q == '0) && (col_q == '0);
        push_e.eol = (col_q == LAST);
        push_e.eof = (row_q == LAST) && (col_q == LAST);
    end

    // rdy_en_q keeps in_ready low through reset and releases it one edge later.
    assign in_ready  = rdy_en_q && (state_q == IDLE || state_q == ACTIVE)
                       && (count_q < (AW+1)'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign head      = mem_q[rd_q];

    assign out_pixel  = out_valid ? head.pix : 8'd0;
    assign out_sof    = out_valid & head.sof;
    assign out_eol    = out_valid & head.eol;
    assign out_eof    = out_valid & head.eof;
    assign frame_done = (state_q == DONE);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + (AW+1)'(1);
        else if (pop && !push)
            count_d = count_q - (AW+1)'(1);
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (push) begin
            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACTIVE: begin
                if (push && push_e.eof)
                    state_d = DRAIN;
                else if (push)
                    state_d = ACTIVE;
            end
            DRAIN:   if (pop && head.eof) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            count_q  <= count_d;
            rdy_en_q <= 1'b1;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_e;
    end

`ifdef SHARP_SAT_COUNT_EN
    logic [$clog2(N*N):0] sat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_q <= '0;
        else if (push)
            sat_q <= push_e.sof ? {{$clog2(N*N){1'b0}}, sat} : sat_q + {{$clog2(N*N){1'b0}}, sat};
    end

    assign sat_count = sat_q;
`endif

endmodule

// File: tb/tb_sharp_out_formatter.sv
// Randomized scoreboard bench for sharp_out_formatter (N=4, DEPTH=4).
module tb_sharp_out_formatter;
    localparam int N    = 4;
    localparam int NPIX = N * N;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pixel;
    logic        out_sof, out_eol, out_eof, frame_done;
`ifdef SHARP_SAT_COUNT_EN
    logic [4:0]  sat_count;
`endif

    logic fix_rdy = 1'b1;
    logic rnd_rdy = 1'b0;
    logic rbit    = 1'b0;
    assign out_ready = rnd_rdy ? rbit : fix_rdy;

    sharp_out_formatter #(.N(N), .M(11), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .frame_done(frame_done)
`ifdef SHARP_SAT_COUNT_EN
        , .sat_count(sat_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1 rbit = 1'($urandom % 2);
    end

    typedef struct {
        int pix;
        bit sof, eol, eof;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0, nerr = 0;
    int   idx = 0, acc_cnt = 0, done_cnt = 0, sat_acc = 0;
    bit   draining = 0, exp_done = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: frame position from a plain sample index, clamp by integer arithmetic.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            idx = 0; draining = 0; exp_done = 0;
        end else begin
            chk("frame_done", int'(frame_done), int'(exp_done));
            if (frame_done) begin
                done_cnt++;
`ifdef SHARP_SAT_COUNT_EN
                chk("sat_count", int'(sat_count), sat_acc);
`endif
            end
            if (draining) chk("in_ready_blocked", int'(in_ready), 0);
            if (frame_done) draining = 0;
            exp_done = 0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pop", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pixel", int'(out_pixel), e.pix);
                    chk("sof", int'(out_sof), int'(e.sof));
                    chk("eol", int'(out_eol), int'(e.eol));
                    chk("eof", int'(out_eof), int'(e.eof));
                    if (e.eof) exp_done = 1;
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                int   s;
                bit   st;
                s = int'($signed(in_data));
                e.pix = (s < 0) ? 0 : ((s > 255) ? 255 : s);
                st = (s < 0) || (s > 255);
                e.sof = (idx == 0);
                e.eol = (idx % N == N - 1);
                e.eof = (idx == NPIX - 1);
                sat_acc = (idx == 0) ? int'(st) : sat_acc + int'(st);
                sb.push_back(e);
                acc_cnt++;
                if (e.eof) draining = 1;
                idx = (idx + 1) % NPIX;
            end
        end
    end

    task automatic send(input logic [11:0] v);
        int tries = 0;
        in_valid = 1'b1;
        in_data  = v;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            tries++;
            if (tries > 200) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_frame();
        while (idx != 0) send(12'($urandom));
    endtask

    task automatic wait_empty();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", int'(t >= 300), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int d0, a0;
        logic [7:0] held;
        logic [11:0] t2 [6];
        t2 = '{12'hFFB, 12'h000, 12'h0FF, 12'h100, 12'h7FF, 12'h800};

        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_pixel", int'(out_pixel), 0);
        chk("rst_tags", int'({out_sof, out_eol, out_eof}), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk) chk("in_ready_pre_rise", int'(in_ready), 0);
        @(negedge clk) chk("in_ready_rise", int'(in_ready), 1);

        // 1: flat frame of 100s
        d0 = done_cnt;
        repeat (NPIX) send(12'd100);
        wait_empty();
        chk("t1_done_pulses", done_cnt - d0, 1);

        // 2: clamp boundaries, then pad the frame
        foreach (t2[i]) send(t2[i]);
        finish_frame();
        wait_empty();

        // 3: stalled sink with steady in_valid
        fix_rdy = 1'b0;
        a0 = acc_cnt;
        in_valid = 1'b1;
        repeat (10) begin
            in_data = 12'($urandom);
            @(posedge clk); #1;
        end
        @(negedge clk);
        held = out_pixel;
        chk("t3_accepted", acc_cnt - a0, 4);
        chk("t3_in_ready", int'(in_ready), 0);
        repeat (3) @(negedge clk);
        chk("t3_pixel_held", int'(out_pixel), int'(held));
        in_valid = 1'b0;
        @(posedge clk); #1 fix_rdy = 1'b1;
        finish_frame();
        wait_empty();

        // 4: next frame's first sample presented during drain
        d0 = done_cnt;
        repeat (NPIX) send(12'($urandom_range(0, 300)));
        send(12'd42);
        chk("t4_done_before_sof", done_cnt - d0, 1);
        finish_frame();
        wait_empty();

        // 5: reset mid-frame with 3 entries queued
        repeat (4) send(12'd7);
        fix_rdy = 1'b0;
        repeat (3) send(12'd9);
        @(negedge clk) chk("t5_queued", int'(out_valid), 1);
        d0 = done_cnt;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", int'(out_valid), 0);
        chk("t5_rst_out_pixel", int'(out_pixel), 0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        fix_rdy = 1'b1;
        repeat (NPIX) send(12'($urandom));
        wait_empty();
        chk("t5_done_pulses", done_cnt - d0, 1);

        // 6: random handshakes over three frames
        rnd_rdy = 1'b1;
        d0 = done_cnt;
        repeat (3 * NPIX) begin
            repeat ($urandom % 2) @(posedge clk);
            #1 send(12'($urandom));
        end
        wait_empty();
        rnd_rdy = 1'b0;
        chk("t6_done_pulses", done_cnt - d0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
